l1_icache_fetch_responder: RTL and testbench

//  Instruction-side L1 responder for the PC/fetch stage. Accepts the fetch address, returns the instruction.

---
 rtl/l1_icache_pkg.sv | 31 +++
 rtl/icache_line_store.sv | 41 ++++
 rtl/l1_icache_fetch_responder.sv | 149 ++++++++++++++
 tb/tb_l1_icache_fetch_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/l1_icache_pkg.sv
// l1_icache_pkg: shared state encoding and address-split width helpers for the L1 I-cache.
// Rev 1.0
`default_nettype none
package l1_icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  // Byte offset within a line: word select plus the two byte bits.
  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int wrd_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_lines, input int line_words);
    return addr_w - off_w(line_words) - idx_w(num_lines);
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_store.sv
// icache_line_store: tag and data arrays, one write port and one combinational read port, no reset.
// Rev 1.0
`default_nettype none
module icache_line_store #(
  parameter int DATA_W     = 32,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24,
  parameter int IDX_W      = 4,
  parameter int WRD_W      = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [WRD_W-1:0]  i_wword,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_tag_we,
  input  logic [TAG_W-1:0]  i_wtag,
  input  logic [IDX_W-1:0]  i_ridx,
  input  logic [WRD_W-1:0]  i_rword,
  output logic [DATA_W-1:0] o_rdata,
  output logic [TAG_W-1:0]  o_rtag
);

  logic [DATA_W-1:0] r_data [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]  r_tag  [NUM_LINES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_data[i_widx][i_wword] <= i_wdata;
    end
    if (i_tag_we) begin
      r_tag[i_widx] <= i_wtag;
    end
  end

  assign o_rdata = r_data[i_ridx][i_rword];
  assign o_rtag  = r_tag[i_ridx];

endmodule
`default_nettype wire

// File: rtl/l1_icache_fetch_responder.sv
// l1_icache_fetch_responder: direct-mapped read-only L1 I-cache with allocate-on-miss line refill.
// Rev 1.0
`default_nettype none
module l1_icache_fetch_responder
  import l1_icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              branch_flush,
  input  logic              invalidate,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              l1_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int WRD_W = wrd_w(LINE_WORDS);
  localparam int TAG_W = tag_w(ADDR_W, NUM_LINES, LINE_WORDS);
  localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(LINE_WORDS - 1);

  state_t               r_state;
  logic [NUM_LINES-1:0] r_valid;
  logic [WRD_W-1:0]     r_beat_cnt;
  logic                 r_inv_pend;
  logic                 r_mem_req;
  logic [TAG_W-1:0]     r_tag;
  logic [IDX_W-1:0]     r_idx;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WRD_W-1:0]  w_word;
  logic [TAG_W-1:0]  w_rtag;
  logic [DATA_W-1:0] w_rdata;
  logic              w_hit;
  logic              w_beat_we;
  logic              w_last;
  logic              w_unused;

  assign w_tag    = pc_addr[ADDR_W-1 -: TAG_W];
  assign w_idx    = pc_addr[OFF_W +: IDX_W];
  assign w_word   = pc_addr[2 +: WRD_W];
  assign w_unused = ^pc_addr[1:0];

  assign w_hit = (r_state == IDLE) & r_valid[w_idx] & (w_rtag == w_tag);

  assign instr       = w_rdata;
  assign instr_valid = w_hit & ~branch_flush;
  assign l1_busy     = ~w_hit;
  assign mem_req     = r_mem_req;
  assign mem_addr    = {r_tag, r_idx, {OFF_W{1'b0}}};

  // A beat landing together with the grant is beat 0; stray beats elsewhere are dropped.
  assign w_beat_we = mem_rvalid & (((r_state == REQ) & mem_gnt) | (r_state == FILL));
  assign w_last    = w_beat_we & (r_state == FILL) & (r_beat_cnt == LAST_BEAT);

  icache_line_store #(
    .DATA_W     (DATA_W),
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W),
    .IDX_W      (IDX_W),
    .WRD_W      (WRD_W)
  ) u_store (
    .clk      (clk),
    .i_we     (w_beat_we),
    .i_widx   (r_idx),
    .i_wword  (r_beat_cnt),
    .i_wdata  (mem_rdata),
    .i_tag_we (w_last),
    .i_wtag   (r_tag),
    .i_ridx   (w_idx),
    .i_rword  (w_word),
    .o_rdata  (w_rdata),
    .o_rtag   (w_rtag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_beat_cnt <= '0;
      r_inv_pend <= 1'b0;
      r_mem_req  <= 1'b0;
      r_tag      <= '0;
      r_idx      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_hit) begin
            r_state        <= REQ;
            r_mem_req      <= 1'b1;
            r_tag          <= w_tag;
            r_idx          <= w_idx;
            r_valid[w_idx] <= 1'b0;
          end
          if (invalidate) begin
            r_valid <= '0;
          end
        end
        REQ: begin
          if (invalidate) begin
            r_inv_pend <= 1'b1;
          end
          if (mem_gnt) begin
            r_state   <= FILL;
            r_mem_req <= 1'b0;
            if (mem_rvalid) begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        FILL: begin
          if (invalidate) begin
            r_inv_pend <= 1'b1;
          end
          if (mem_rvalid) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (r_beat_cnt == LAST_BEAT) begin
              r_valid[r_idx] <= 1'b1;
              r_state        <= DONE;
            end
          end
        end
        DONE: begin
          // A fence.i seen during the refill also drops the line just filled.
          if (r_inv_pend | invalidate) begin
            r_valid <= '0;
          end
          r_inv_pend <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l1_icache_fetch_responder.sv
// tb_l1_icache_fetch_responder: directed refill sequences plus a table of hit vectors.
`default_nettype none
module tb_l1_icache_fetch_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic        branch_flush;
  logic        invalidate;
  logic [31:0] instr;
  logic        instr_valid;
  logic        l1_busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic        exp_busy;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  l1_icache_fetch_responder dut (
    .clk          (clk),
    .reset        (reset),
    .pc_addr      (pc_addr),
    .branch_flush (branch_flush),
    .invalidate   (invalidate),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .l1_busy      (l1_busy),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Miss on addr, optional grant delay with a stray beat, then four beats base+0..base+3.
  task automatic refill(input logic [31:0] addr, input logic [31:0] base, input int dly,
                        input bit stray, input bit same, input bit in_req);
    logic [31:0] line;
    logic [1:0]  wsel;
    int          first;
    line    = addr & 32'hFFFF_FFF0;
    wsel    = addr[3:2];
    pc_addr = addr;
    if (!in_req) begin
      #1;
      chk("miss_busy", l1_busy, 1);
      chk("miss_valid", instr_valid, 0);
      step();
    end
    for (int d = 0; d < dly; d++) begin
      mem_rvalid = stray && (d == 0);
      mem_rdata  = 32'hDEAD_BEEF;
      #1;
      chk("req_held", mem_req, 1);
      chk("req_busy", l1_busy, 1);
      step();
    end
    mem_gnt    = 1'b1;
    mem_rvalid = same;
    mem_rdata  = base;
    #1;
    chk("req_addr", mem_addr, line);
    chk("req_on", mem_req, 1);
    step();
    mem_gnt = 1'b0;
    first   = same ? 1 : 0;
    for (int k = first; k < 4; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + k;
      #1;
      chk("fill_req_low", mem_req, 0);
      chk("fill_busy", l1_busy, 1);
      step();
    end
    mem_rvalid = 1'b0;
    #1;
    chk("done_busy", l1_busy, 1);
    chk("done_valid", instr_valid, 0);
    step();
    #1;
    chk("hit_instr", instr, base + wsel);
    chk("hit_valid", instr_valid, 1);
    chk("hit_busy", l1_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h04, 1'b0, 32'hA1, 1'b1, 1'b0};
    tbl[1] = '{32'h08, 1'b0, 32'hA2, 1'b1, 1'b0};
    tbl[2] = '{32'h0C, 1'b0, 32'hA3, 1'b1, 1'b0};
    tbl[3] = '{32'h00, 1'b1, 32'hA0, 1'b0, 1'b0};
    tbl[4] = '{32'h10, 1'b0, 32'hB0, 1'b1, 1'b0};
    tbl[5] = '{32'h1C, 1'b0, 32'hB3, 1'b1, 1'b0};
    tbl[6] = '{32'h24, 1'b0, 32'hC1, 1'b1, 1'b0};
    tbl[7] = '{32'h28, 1'b1, 32'hC2, 1'b0, 1'b0};

    reset = 1'b1; pc_addr = 32'h0; branch_flush = 1'b0; invalidate = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    step(); step();
    chk("rst_busy", l1_busy, 1);
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", mem_req, 0);
    reset = 1'b0;

    // Cold miss at 0x0, then two back-to-back misses with grant and beat 0 together.
    refill(32'h0, 32'hA0, 0, 1'b0, 1'b0, 1'b0);
    refill(32'h10, 32'hB0, 0, 1'b0, 1'b1, 1'b0);
    refill(32'h20, 32'hC0, 0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      pc_addr      = tbl[i].pc;
      branch_flush = tbl[i].flush;
      #1;
      chk("tbl_instr", instr, tbl[i].exp_instr);
      chk("tbl_valid", instr_valid, tbl[i].exp_valid);
      chk("tbl_busy", l1_busy, tbl[i].exp_busy);
      step();
    end
    branch_flush = 1'b0;

    // Alias on idx 0 with a new tag evicts 0x0.
    refill(32'h100, 32'hD0, 0, 1'b0, 1'b0, 1'b0);
    pc_addr = 32'h0;
    #1;
    chk("alias_miss", l1_busy, 1);
    refill(32'h0, 32'hA0, 0, 1'b0, 1'b0, 1'b1 ^ 1'b1);

    // Late grant with a stray beat while requesting.
    refill(32'h34, 32'hE0, 5, 1'b1, 1'b0, 1'b0);

    // Reset after two of four beats; leftover beats must not complete the line.
    pc_addr = 32'h40;
    #1;
    chk("r4_miss", l1_busy, 1);
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hF0 + k;
      step();
    end
    reset = 1'b1; mem_rdata = 32'hF2;
    #1;
    chk("r4_rst_req", mem_req, 0);
    chk("r4_rst_busy", l1_busy, 1);
    step();
    reset = 1'b0; mem_rdata = 32'hF3;
    #1;
    chk("r4_post_busy", l1_busy, 1);
    chk("r4_post_valid", instr_valid, 0);
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("r4_reissue", mem_req, 1);
    chk("r4_addr", mem_addr, 32'h40);
    refill(32'h48, 32'h50, 0, 1'b0, 1'b0, 1'b1);

    // Fence during a refill: line completes, then every line misses.
    pc_addr = 32'h50;
    #1;
    chk("inv_miss", l1_busy, 1);
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h60 + k;
      invalidate = (k == 1);
      step();
    end
    mem_rvalid = 1'b0; invalidate = 1'b0;
    #1;
    chk("inv_done_busy", l1_busy, 1);
    step();
    #1;
    chk("inv_line_gone", l1_busy, 1);
    chk("inv_line_valid", instr_valid, 0);
    pc_addr = 32'h48;
    #1;
    chk("inv_other_gone", l1_busy, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
